// File: rtl/zet_pic_pkg.sv
// Shared constants and types for the zet_pic interrupt controller.
// Register port addresses, OCW2 EOI codes, FSM encoding and reset defaults.
package zet_pic_pkg;

    localparam logic       PIC_ADDR_CMD  = 1'b0;
    localparam logic       PIC_ADDR_DATA = 1'b1;

    localparam logic [2:0] OCW2_EOI_NONSPEC = 3'b001;
    localparam logic [2:0] OCW2_EOI_SPEC    = 3'b011;

    localparam logic [7:0] VEC_RST_DEF = 8'h08;
    localparam logic [7:0] IMR_RST_DEF = 8'hFF;

    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_WAIT_ICW2 = 1'b1
    } pic_state_t;

endpackage

// File: rtl/zet_pic_prio.sv
// Lowest-set-bit finder: index of the highest-priority (lowest numbered) set bit.
module zet_pic_prio (
    input  logic [7:0] bits,
    output logic       valid,
    output logic [2:0] idx
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        valid = |bits;
        idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bits[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/zet_pic.sv
// 8-input fixed-priority interrupt controller with intr/inta handshake and a
// two-address byte register port for ICW1/ICW2, OCW1 (mask), OCW2 (EOI) and OCW3.
module zet_pic
    import zet_pic_pkg::*;
#(
    parameter logic [7:0] VEC_RST = VEC_RST_DEF,
    parameter logic [7:0] IMR_RST = IMR_RST_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq,
    output logic       intr,
    input  logic       inta,
    output logic [7:0] vector,
    input  logic       io_cs,
    input  logic       io_we,
    input  logic       io_addr,
    input  logic [7:0] io_wdat,
    output logic [7:0] io_rdat
);

    logic [7:0] irq_s1, irq_s2, irq_s3;
    logic [7:0] irr, isr, imr;
    logic [4:0] base;
    logic       rd_isr;
    pic_state_t state;

    logic [7:0] irq_edge, req;
    logic       req_valid, isr_valid, pend;
    logic [2:0] win, top;

    logic [7:0] irr_n, isr_n, imr_n, vector_n, rdat_n;
    logic [4:0] base_n;
    logic       rd_isr_n;
    pic_state_t state_n;

    assign irq_edge = irq_s2 & ~irq_s3;
    assign req      = irr & ~imr;

    zet_pic_prio u_prio_req (.bits(req), .valid(req_valid), .idx(win));
    zet_pic_prio u_prio_isr (.bits(isr), .valid(isr_valid), .idx(top));

    assign pend = req_valid && (!isr_valid || (win < top));

    // NOTE: combinational next-state uses blocking '=' so later statements see
    // earlier ones (ack then EOI then ICW1); the registers below use '<='.
    always_comb begin
        irr_n    = irr | irq_edge;
        isr_n    = isr;
        imr_n    = imr;
        base_n   = base;
        rd_isr_n = rd_isr;
        state_n  = state;
        vector_n = vector;
        rdat_n   = io_rdat;

        // An edge on the acknowledged line in the same cycle is dropped here.
        if (inta) begin
            if (pend) begin
                isr_n[win] = 1'b1;
                irr_n[win] = 1'b0;
                vector_n   = {base, win};
            end else begin
                vector_n   = {base, 3'd7};
            end
        end

        if (io_cs && io_we) begin
            if (io_addr == PIC_ADDR_CMD) begin
                if (io_wdat[4]) begin
                    isr_n   = 8'h00;
                    irr_n   = 8'h00;
                    imr_n   = 8'h00;
                    state_n = ST_WAIT_ICW2;
                end else if (io_wdat[3] == 1'b0) begin
                    // Nonspecific EOI targets the pre-ack in-service priority.
                    if (io_wdat[7:5] == OCW2_EOI_NONSPEC && isr_valid)
                        isr_n[top] = 1'b0;
                    else if (io_wdat[7:5] == OCW2_EOI_SPEC)
                        isr_n[io_wdat[2:0]] = 1'b0;
                end else if (io_wdat[1]) begin
                    rd_isr_n = io_wdat[0];
                end
            end else if (state == ST_WAIT_ICW2) begin
                base_n  = io_wdat[7:3];
                state_n = ST_RUN;
            end else begin
                imr_n = io_wdat;
            end
        end

        if (io_cs && !io_we) begin
            if (io_addr == PIC_ADDR_DATA) rdat_n = imr;
            else                          rdat_n = rd_isr ? isr : irr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_s1  <= 8'h00;
            irq_s2  <= 8'h00;
            irq_s3  <= 8'h00;
            irr     <= 8'h00;
            isr     <= 8'h00;
            imr     <= IMR_RST;
            base    <= VEC_RST[7:3];
            rd_isr  <= 1'b0;
            state   <= ST_RUN;
            intr    <= 1'b0;
            vector  <= {VEC_RST[7:3], 3'd7};
            io_rdat <= 8'h00;
        end else begin
            irq_s1  <= irq;
            irq_s2  <= irq_s1;
            irq_s3  <= irq_s2;
            irr     <= irr_n;
            isr     <= isr_n;
            imr     <= imr_n;
            base    <= base_n;
            rd_isr  <= rd_isr_n;
            state   <= state_n;
            intr    <= pend && !inta;
            vector  <= vector_n;
            io_rdat <= rdat_n;
        end
    end

endmodule

// File: tb/tb_zet_pic.sv
// Directed bench for zet_pic: a per-cycle reference model plus hand-computed
// checks of the documented interrupt scenarios.
module tb_zet_pic;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq = 8'h00;
    logic       intr;
    logic       inta = 1'b0;
    logic [7:0] vector;
    logic       io_cs = 1'b0;
    logic       io_we = 1'b0;
    logic       io_addr = 1'b0;
    logic [7:0] io_wdat = 8'h00;
    logic [7:0] io_rdat;

    int n_vec = 0;
    int n_err = 0;

    zet_pic dut (
        .clk(clk), .rst(rst), .irq(irq), .intr(intr), .inta(inta),
        .vector(vector), .io_cs(io_cs), .io_we(io_we), .io_addr(io_addr),
        .io_wdat(io_wdat), .io_rdat(io_rdat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] irr, isr, imr;
        logic [4:0] base;
        logic       rd_isr, wait_icw2, intr;
        logic [7:0] vector, rdat;
        logic [7:0] h0, h1, h2;   // irq samples 1, 2 and 3 clocks ago
    } mstate_t;

    mstate_t m;

    function automatic int lowest(logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    function automatic mstate_t model_reset();
        mstate_t r = '0;
        r.imr    = 8'hFF;
        r.base   = 5'd1;
        r.vector = 8'h0F;
        return r;
    endfunction

    function automatic mstate_t model_next(mstate_t s, logic [7:0] irq_now, logic ack,
                                           logic cs, logic we, logic addr, logic [7:0] wd);
        mstate_t    n    = s;
        logic [7:0] pr   = s.irr & ~s.imr;
        int         w    = lowest(pr);
        int         t    = lowest(s.isr);
        logic       pend = (w < 8) && (w < t);
        n.irr = s.irr | (s.h1 & ~s.h2);
        n.h0  = irq_now;
        n.h1  = s.h0;
        n.h2  = s.h1;
        if (ack) begin
            if (pend) begin
                n.isr[w] = 1'b1;
                n.irr[w] = 1'b0;
                n.vector = {s.base, 3'(w)};
            end else begin
                n.vector = {s.base, 3'd7};
            end
        end
        if (cs && we) begin
            if (!addr) begin
                if (wd[4]) begin
                    n.isr = 8'h00; n.irr = 8'h00; n.imr = 8'h00; n.wait_icw2 = 1'b1;
                end else if (wd[4:3] == 2'b00) begin
                    if (wd[7:5] == 3'd1 && t < 8) n.isr[t] = 1'b0;
                    if (wd[7:5] == 3'd3)          n.isr[wd[2:0]] = 1'b0;
                end else if (wd[1]) begin
                    n.rd_isr = wd[0];
                end
            end else if (s.wait_icw2) begin
                n.base = wd[7:3];
                n.wait_icw2 = 1'b0;
            end else begin
                n.imr = wd;
            end
        end
        if (cs && !we) n.rdat = addr ? s.imr : (s.rd_isr ? s.isr : s.irr);
        n.intr = pend && !ack;
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= model_reset();
        else      m <= model_next(m, irq, inta, io_cs, io_we, io_addr, io_wdat);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (rst) begin
            check("model_intr",   {7'd0, intr}, {7'd0, m.intr});
            check("model_vector", vector,       m.vector);
            check("model_rdat",   io_rdat,      m.rdat);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        @(negedge clk);
        io_cs = 1'b1; io_we = 1'b1; io_addr = a; io_wdat = d;
        @(negedge clk);
        io_cs = 1'b0; io_we = 1'b0;
    endtask

    task automatic rd(input logic a, output logic [7:0] d);
        @(negedge clk);
        io_cs = 1'b1; io_we = 1'b0; io_addr = a;
        @(negedge clk);
        io_cs = 1'b0;
        d = io_rdat;
    endtask

    task automatic ack(input string name, input logic [7:0] exp_vec);
        @(negedge clk);
        inta = 1'b1;
        @(negedge clk);
        inta = 1'b0;
        check({name, "_vector"}, vector, exp_vec);
        check({name, "_intr_low"}, {7'd0, intr}, 8'h00);
    endtask

    task automatic wait_intr(input string name);
        int k = 0;
        while (intr !== 1'b1 && k < 12) begin
            @(negedge clk);
            k++;
        end
        check({name, "_intr_rise"}, {7'd0, intr}, 8'h01);
    endtask

    logic [7:0] d;

    initial begin
        rst = 1'b1;
        #1 rst = 1'b0;
        tick(3);
        check("rst_intr",   {7'd0, intr}, 8'h00);
        check("rst_vector", vector,       8'h0F);
        check("rst_rdat",   io_rdat,      8'h00);
        rst = 1'b1;
        rd(1'b1, d); check("rst_imr", d, 8'hFF);

        // irq[3] unmasked: intr exactly 4 clocks after the edge
        wr(1'b1, 8'h00);
        @(negedge clk); irq[3] = 1'b1;
        tick(3); check("irq3_intr_early", {7'd0, intr}, 8'h00);
        tick(1); check("irq3_intr_4clk",  {7'd0, intr}, 8'h01);
        ack("irq3", 8'h0B);
        rd(1'b0, d); check("irq3_irr", d, 8'h00);
        wr(1'b0, 8'h0B);
        rd(1'b0, d); check("irq3_isr", d, 8'h08);
        wr(1'b0, 8'h20);
        rd(1'b0, d); check("irq3_isr_eoi", d, 8'h00);
        irq = 8'h00;

        // ICW1/ICW2 reprogram base, simultaneous irq0/irq5
        wr(1'b0, 8'h11);
        wr(1'b1, 8'h70);
        @(negedge clk); irq[0] = 1'b1; irq[5] = 1'b1;
        wait_intr("icw_irq0");
        ack("icw_irq0", 8'h70);
        tick(3); check("icw_irq5_blocked", {7'd0, intr}, 8'h00);
        wr(1'b0, 8'h20);
        wait_intr("icw_irq5");
        ack("icw_irq5", 8'h75);
        wr(1'b0, 8'h20);
        irq = 8'h00;

        // nesting: irq6 in service, irq2 preempts, irq7 waits for both EOIs
        @(negedge clk); irq[6] = 1'b1;
        wait_intr("nest_irq6");
        ack("nest_irq6", 8'h76);
        @(negedge clk); irq[2] = 1'b1;
        wait_intr("nest_irq2");
        ack("nest_irq2", 8'h72);
        rd(1'b0, d); check("nest_isr", d, 8'h44);
        @(negedge clk); irq[7] = 1'b1;
        tick(8); check("nest_irq7_blocked", {7'd0, intr}, 8'h00);
        wr(1'b0, 8'h20);
        tick(6); check("nest_irq7_blocked2", {7'd0, intr}, 8'h00);
        rd(1'b0, d); check("nest_isr_one_eoi", d, 8'h40);
        wr(1'b0, 8'h20);
        wait_intr("nest_irq7");
        ack("nest_irq7", 8'h77);
        wr(1'b0, 8'h20);
        irq = 8'h00;

        // masked request held in irr until unmasked
        wr(1'b1, 8'h02);
        @(negedge clk); irq[1] = 1'b1;
        tick(8); check("mask_no_intr", {7'd0, intr}, 8'h00);
        wr(1'b0, 8'h0A);
        rd(1'b0, d); check("mask_irr", d, 8'h02);
        wr(1'b1, 8'h00);
        rd(1'b1, d); check("mask_imr", d, 8'h00);
        wait_intr("unmask");
        ack("unmask", 8'h71);
        wr(1'b0, 8'h0B);
        rd(1'b0, d); check("unmask_isr", d, 8'h02);
        wr(1'b0, 8'h20);
        irq = 8'h00;

        // spurious acknowledge leaves isr alone
        @(negedge clk); irq[4] = 1'b1;
        wait_intr("spur_irq4");
        ack("spur_irq4", 8'h74);
        ack("spurious", 8'h77);
        rd(1'b0, d); check("spur_isr", d, 8'h10);
        wr(1'b0, 8'h20);
        irq = 8'h00;

        // specific EOI on isr=0x0C
        @(negedge clk); irq[3] = 1'b1;
        wait_intr("seoi_irq3");
        ack("seoi_irq3", 8'h73);
        @(negedge clk); irq[2] = 1'b1;
        wait_intr("seoi_irq2");
        ack("seoi_irq2", 8'h72);
        rd(1'b0, d); check("seoi_isr_before", d, 8'h0C);
        wr(1'b0, 8'h63);
        rd(1'b0, d); check("seoi_isr_after", d, 8'h04);
        wr(1'b0, 8'h20);
        irq = 8'h00;

        // reset while a request is pending
        @(negedge clk); irq[5] = 1'b1;
        tick(4); check("rst_pending_intr", {7'd0, intr}, 8'h01);
        #1 rst = 1'b0;
        #1;
        check("midrst_intr",   {7'd0, intr}, 8'h00);
        check("midrst_vector", vector,       8'h0F);
        check("midrst_rdat",   io_rdat,      8'h00);
        irq = 8'h00;
        tick(2);
        rst = 1'b1;
        rd(1'b1, d); check("midrst_imr", d, 8'hFF);
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
